// File: rtl/cbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cbd_pkg
//  Description : Shared widths and enums for the instruction/data memory
//                arbiter: default address/line widths, FSM states, owners.
//  Revision    : 1.0  initial release
// ============================================================================
package cbd_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 128;
  // Byte offset bits inside one line (16-byte lines).
  localparam int LINE_OFS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin grant. Holds the last-granted owner;
//                on a tie the side not granted last wins.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import cbd_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  input  owner_t upd_owner,
  output logic   gnt_i,
  output logic   gnt_d
);

  owner_t r_last;
  logic   w_pick_d;

  // Last-granted owner; resets to data so the first tie goes to instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= OWN_D;
    end else if (upd) begin
      r_last <= upd_owner;
    end
  end

  // Data wins when it is the only requester or when instruction went last.
  always_comb begin
    w_pick_d = req_d && (!req_i || (r_last == OWN_I));
  end

  assign gnt_d = en && w_pick_d;
  assign gnt_i = en && req_i && !w_pick_d;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one fixed-latency line memory between an instruction
//                read port and a data read/write port. One transaction at a
//                time: IDLE (grant) -> BUSY (MEM_LAT cycles) -> RESP (pulse).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import cbd_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int MEM_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  input  logic [ADDR_W-1:0]            i_req_addr,
  output logic                         i_req_ready,
  output logic                         i_rsp_valid,
  output logic [LINE_W-1:0]            i_rsp_data,
  input  logic                         d_req_valid,
  input  logic                         d_req_we,
  input  logic [ADDR_W-1:0]            d_req_addr,
  input  logic [LINE_W-1:0]            d_req_wdata,
  output logic                         d_req_ready,
  output logic                         d_rsp_valid,
  output logic [LINE_W-1:0]            d_rsp_data,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-LINE_OFS_W-1:0] mem_addr,
  output logic [LINE_W-1:0]            mem_wdata,
  input  logic [LINE_W-1:0]            mem_rdata
);

  // Counter preload: BUSY lasts this value + 1 cycles.
  localparam logic [3:0] c_lat_m1 = 4'(MEM_LAT - 1);

  state_t                         r_state;
  owner_t                         r_owner;
  logic                           r_we;
  logic [ADDR_W-LINE_OFS_W-1:0]   r_addr;
  logic [LINE_W-1:0]              r_wdata;
  logic [3:0]                     r_cnt;
  logic                           r_mem_en;
  logic                           r_mem_we;
  logic                           r_i_rsp_valid;
  logic                           r_d_rsp_valid;
  logic [LINE_W-1:0]              r_i_rsp_data;
  logic [LINE_W-1:0]              r_d_rsp_data;

  logic w_arb_en;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_hs;
  logic w_resp;
  logic w_unused;

  // Grants only exist in IDLE; rst is folded in so ready drops the moment
  // reset is asserted, not at the next edge.
  assign w_arb_en = rst && (r_state == IDLE);
  assign w_resp   = (r_state == RESP);

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (w_arb_en),
    .req_i     (i_req_valid),
    .req_d     (d_req_valid),
    .upd       (w_resp),
    .upd_owner (r_owner),
    .gnt_i     (w_gnt_i),
    .gnt_d     (w_gnt_d)
  );

  assign w_hs = w_gnt_i || w_gnt_d;

  // Line-aligned access: the byte offset within a line is never used.
  assign w_unused = ^{i_req_addr[LINE_OFS_W-1:0], d_req_addr[LINE_OFS_W-1:0]};

  // Transaction FSM: latch the winner, hold the memory port for MEM_LAT
  // cycles, capture the returned line, then pulse the owner's response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_owner       <= OWN_I;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= 4'd0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_d_rsp_data  <= '0;
    end else begin
      r_i_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_owner  <= w_gnt_d ? OWN_D : OWN_I;
            r_we     <= w_gnt_d && d_req_we;
            r_addr   <= w_gnt_d ? d_req_addr[ADDR_W-1:LINE_OFS_W]
                                : i_req_addr[ADDR_W-1:LINE_OFS_W];
            r_wdata  <= w_gnt_d ? d_req_wdata : '0;
            r_cnt    <= c_lat_m1;
            r_mem_en <= 1'b1;
            r_mem_we <= w_gnt_d && d_req_we;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= RESP;
            if (r_owner == OWN_I) begin
              r_i_rsp_valid <= 1'b1;
              r_i_rsp_data  <= mem_rdata;
            end else begin
              r_d_rsp_valid <= 1'b1;
              r_d_rsp_data  <= r_we ? '0 : mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i_req_ready = w_gnt_i;
  assign d_req_ready = w_gnt_d;
  assign i_rsp_valid = r_i_rsp_valid;
  assign d_rsp_valid = r_d_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign d_rsp_data  = r_d_rsp_data;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter (MEM_LAT = 4). A
//                transaction-level model predicts every output each cycle;
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int MEM_LAT = 4;
  localparam int IDX_W   = ADDR_W - 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_v = 1'b0;
  logic [ADDR_W-1:0] i_a = '0;
  logic              d_v = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_a = '0;
  logic [LINE_W-1:0] d_wd = '0;

  logic              i_req_ready, i_rsp_valid, d_req_ready, d_rsp_valid;
  logic [LINE_W-1:0] i_rsp_data, d_rsp_data, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [IDX_W-1:0]  mem_addr;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_v), .i_req_addr(i_a), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_v), .d_req_we(d_we), .d_req_addr(d_a), .d_req_wdata(d_wd),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory contents: every 32-bit word of line n is 0x5A000000 + n.
  function automatic logic [LINE_W-1:0] line_of(input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w = 32'h5A00_0000 + {4'b0, idx};
    return {4{w}};
  endfunction

  assign mem_rdata = line_of(mem_addr);

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One transaction occupies cycles 0 (handshake) .. MEM_LAT+1 (response);
  // m_t counts cycles since the handshake.
  bit               m_busy;
  int               m_t;
  bit               m_own_d;
  bit               m_last_d;
  bit               m_we;
  logic [IDX_W-1:0] m_idx;
  logic [LINE_W-1:0] m_wdata, m_idata, m_ddata;

  initial begin
    int win;   // 0 none, 1 instruction, 2 data
    bit e_ir, e_dr, e_iv, e_dv, e_en, e_we;
    m_busy = 0; m_last_d = 1; m_idata = '0; m_ddata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_last_d = 1; m_idata = '0; m_ddata = '0;
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_i_rsp_valid", i_rsp_valid, 0);
        chk("rst_d_rsp_valid", d_rsp_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rsp_data", i_rsp_data, 0);
        chk("rst_d_rsp_data", d_rsp_data, 0);
      end else begin
        win = 0; e_ir = 0; e_dr = 0; e_iv = 0; e_dv = 0; e_en = 0; e_we = 0;
        if (!m_busy) begin
          if (i_v && d_v) win = m_last_d ? 1 : 2;
          else if (i_v)   win = 1;
          else if (d_v)   win = 2;
          e_ir = (win == 1);
          e_dr = (win == 2);
        end else if (m_t <= MEM_LAT) begin
          e_en = 1;
          e_we = m_we;
          chk("m_mem_addr", mem_addr, m_idx);
          if (m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
        end else begin
          if (m_own_d) begin
            e_dv = 1;
            m_ddata = m_we ? '0 : line_of(m_idx);
          end else begin
            e_iv = 1;
            m_idata = line_of(m_idx);
          end
        end
        chk("m_i_ready", i_req_ready, e_ir);
        chk("m_d_ready", d_req_ready, e_dr);
        chk("m_i_rsp_valid", i_rsp_valid, e_iv);
        chk("m_d_rsp_valid", d_rsp_valid, e_dv);
        chk("m_mem_en", mem_en, e_en);
        chk("m_mem_we", mem_we, e_we);
        chk("m_i_rsp_data", i_rsp_data, m_idata);
        chk("m_d_rsp_data", d_rsp_data, m_ddata);
        if (win != 0) begin
          m_busy  = 1;
          m_t     = 1;
          m_own_d = (win == 2);
          m_we    = (win == 2) && d_we;
          m_idx   = (win == 2) ? d_a[ADDR_W-1:4] : i_a[ADDR_W-1:4];
          m_wdata = d_wd;
        end else if (m_busy) begin
          if (m_t == MEM_LAT + 1) begin
            m_busy   = 0;
            m_last_d = m_own_d;
          end else begin
            m_t++;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 0; i_v = 0; d_v = 0; d_we = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Both sides raise a read together and each holds until accepted.
  task automatic run_pair(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                          output int ic, output int dc);
    bit gi, gd;
    ic = -1; dc = -1;
    @(posedge clk); #1;
    i_v = 1; i_a = ia; d_v = 1; d_we = 0; d_a = da;
    for (int k = 0; k < 40 && (i_v || d_v); k++) begin
      @(negedge clk);
      gi = i_v && i_req_ready;
      gd = d_v && d_req_ready;
      if (gi) ic = cyc;
      if (gd) dc = cyc;
      @(posedge clk); #1;
      if (gi) i_v = 0;
      if (gd) d_v = 0;
    end
    chk("pair_timeout", {i_v, d_v}, 2'b00);
    i_v = 0; d_v = 0;
  endtask

  // Waits (bounded) for the instruction request to be accepted.
  task automatic wait_i_ready(input string name, output int c);
    c = -1;
    for (int k = 0; k < 20 && c < 0; k++) begin
      @(negedge clk);
      if (i_req_ready) c = cyc;
    end
    chk(name, (c < 0), 0);
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int ic, dc, ic2, dc2, c1, c2, pulses;
    logic [LINE_W-1:0] aa;

    do_reset();

    // Lone instruction read of 0x10: line 1, response 5 cycles later.
    @(posedge clk); #1; i_v = 1; i_a = 32'h10;
    @(negedge clk); chk("t1_ready_c0", i_req_ready, 1);
    @(posedge clk); #1; i_v = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_mem_en", mem_en, 1);
      chk("t1_mem_addr", mem_addr, 1);
    end
    @(negedge clk);
    chk("t1_rsp_valid_c5", i_rsp_valid, 1);
    chk("t1_rsp_line1", i_rsp_data, 128'h5A000001_5A000001_5A000001_5A000001);
    idle(3);

    // Tie from reset: instruction first, data six cycles later; next tie
    // goes back to instruction.
    do_reset();
    run_pair(32'h30, 32'h40, ic, dc);
    chk("t2_i_first", (ic >= 0 && ic < dc), 1);
    chk("t2_d_at_6", dc - ic, 6);
    run_pair(32'h50, 32'h60, ic2, dc2);
    chk("t2_third_pair_i", (ic2 >= 0 && ic2 < dc2), 1);
    chk("t2_third_pair_gap", dc2 - ic2, 6);
    idle(8);

    // Data write of 0x20 with an all-0xAA line.
    aa = {16{8'hAA}};
    @(posedge clk); #1; d_v = 1; d_we = 1; d_a = 32'h20; d_wd = aa;
    @(negedge clk); chk("t3_d_ready", d_req_ready, 1);
    @(posedge clk); #1; d_v = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, 2);
      chk("t3_mem_wdata", mem_wdata, aa);
    end
    @(negedge clk);
    chk("t3_d_rsp_valid", d_rsp_valid, 1);
    chk("t3_d_rsp_zero", d_rsp_data, 0);
    d_we = 0;
    idle(3);

    // Reset asserted in the second BUSY cycle aborts the read.
    @(posedge clk); #1; i_v = 1; i_a = 32'h50;
    @(negedge clk); chk("t4_ready", i_req_ready, 1);
    @(posedge clk); #1; i_v = 0;
    @(posedge clk); #2; d_v = 1; d_a = 32'h80; rst = 0;
    #1;
    chk("t4_async_mem_en", mem_en, 0);
    chk("t4_async_d_ready", d_req_ready, 0);
    chk("t4_async_i_rsp", i_rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1; d_v = 0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i_rsp_valid || d_rsp_valid) pulses++;
    end
    chk("t4_no_rsp_after_abort", pulses, 0);

    // Instruction valid held for two reads; offset 0xF vs 0x0 same line.
    @(posedge clk); #1; i_v = 1; i_a = 32'h7F;
    wait_i_ready("t5_first_ready", c1);
    @(posedge clk); #1; i_a = 32'h70;
    @(negedge clk); chk("t5_first_addr", mem_addr, 7);
    wait_i_ready("t5_second_ready", c2);
    chk("t5_gap_6", c2 - c1, 6);
    @(posedge clk); #1; i_v = 0;
    @(negedge clk); chk("t5_second_addr", mem_addr, 7);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
